lfsr_checker: RTL and testbench
===============================

LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 Parameter LOCK_COUNT, default 32: consecutive correct predictions in VERIFY that are required to declare lock.
REQ-002 Parameter LOSS_THRESH, default 4: mismatches within one window, while LOCKED, that cause loss of lock.
REQ-003 Parameter WINDOW, default 64: number of valid bits per loss-detection window.
REQ-004 Port clk, input, 1: single clock; all logic SHALL be clocked on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port bit_valid, input, 1: bit_in is sampled only on cycles where this is high.
REQ-007 Port bit_in, input, 1: received serial PRBS bit.
REQ-008 Port locked, output, 1: high while the checker is in the LOCKED state.
REQ-009 Port error_pulse, output, 1: one-cycle pulse for each mismatch detected while LOCKED.
REQ-010 Port sync_lost, output, 1: one-cycle pulse when the checker leaves LOCKED.
REQ-011 Port error_count, output, 16: saturating count of mismatches detected while LOCKED.

Function
REQ-012 The block SHALL keep a 16-bit history register h, where h[0] is the newest accepted bit.
REQ-013 Predicted next bit SHALL be h[15]^h[13]^h[12]^h[10], i.e. polynomial taps 16,14,13,11, matching the team's left-shifting 16-bit generator that outputs its LSB.
REQ-014 Every accepted bit SHALL be written as h <= {h[14:0], b}; nothing changes on cycles where bit_valid=0.
REQ-015 States SHALL be HUNT, VERIFY and LOCKED.
REQ-016 In HUNT and VERIFY, b SHALL be bit_in.
REQ-017 In LOCKED, b SHALL be the predicted bit (flywheel), so a single bit error does not propagate.
REQ-018 HUNT behaviour:
- A 5-bit fill counter counts accepted bits.
- After the 16th accepted bit, go to VERIFY if the updated h is nonzero.
- If the updated h is all-zero, restart the fill counter and stay in HUNT.
REQ-019 VERIFY behaviour:
- Each accepted bit equal to the prediction increments a run counter.
- On reaching LOCK_COUNT, go to LOCKED.
- Any mismatch clears the run and fill counters and returns to HUNT.
REQ-020 LOCKED behaviour:
- Each accepted bit advances a window counter and is compared against the prediction.
- A mismatch pulses error_pulse, increments error_count and increments the window miss counter.
REQ-021 When the miss counter reaches LOSS_THRESH, the state SHALL go to HUNT, sync_lost SHALL pulse, and all counters except error_count SHALL clear.
REQ-022 Window end: on the WINDOW-th accepted bit, that bit's mismatch is counted first; the window and miss counters then clear, unless loss of lock was triggered.
REQ-023 All outputs SHALL be registered: locked, error_pulse and sync_lost change in the cycle after the deciding bit_valid sample.
REQ-024 error_count SHALL saturate at 16'hFFFF and never wrap.
REQ-025 error_count SHALL be retained across loss and regain of lock.

Reset
REQ-026 While reset is high, the following SHALL hold on the next rising clk edge:
- state = HUNT, h = 0, and all counters = 0.
- locked = 0, error_pulse = 0, sync_lost = 0, error_count = 0.
REQ-027 Reset SHALL take priority over bit_valid.
REQ-028 Reset asserted mid-LOCKED SHALL drop locked without pulsing sync_lost.

Configuration
REQ-029 Macro LFSR_CHECKER_STATS_EN defined: error_count SHALL be implemented as specified.
REQ-030 Macro LFSR_CHECKER_STATS_EN undefined: error_count SHALL be constant 0 and its register omitted; all other behaviour unchanged.

Structure
REQ-031 A shared package lfsr_pkg SHALL hold:
- the LFSR width (16);
- the tap positions;
- the generator seed 16'h0001;
- the checker state encoding.
REQ-032 Saturating counters SHALL use one sub-module, lfsr_sat_counter, parameterised by width and with enable/clear inputs; it is instanced for error_count.

Verification
REQ-033 Reset generator and checker together, bit_valid=1 continuously -> locked rises after the 48th bit (16+32); error_count=0 after 1000 bits.
REQ-034 While locked, invert bit 100 only -> exactly one error_pulse, error_count=1, locked stays 1, no further errors.
REQ-035 While locked, invert 4 bits within one 64-bit window -> sync_lost pulses once, locked=0; relock after 48 further clean bits; error_count=4.
REQ-036 Drive 200 zero bits -> locked never asserts and the state stays in HUNT.
REQ-037 Drive bit_valid high every 3rd cycle -> lock after 48 valid bits (about 144 cycles); assert reset while locked -> all outputs 0 next cycle.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared constants for the PRBS-16 generator/checker pair: width, taps, seed
// and the checker state encoding.
package lfsr_pkg;

  localparam int LFSR_W = 16;

  // History bit indices for polynomial taps 16,14,13,11 (h[0] is the newest bit)
  localparam int TAP_A = 15;
  localparam int TAP_B = 13;
  localparam int TAP_C = 12;
  localparam int TAP_D = 10;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'h0001;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } lfsr_state_e;

  function automatic logic lfsr_predict(input logic [LFSR_W-1:0] h);
    return h[TAP_A] ^ h[TAP_B] ^ h[TAP_C] ^ h[TAP_D];
  endfunction

endpackage

// File: rtl/lfsr_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module lfsr_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/lfsr_checker.sv
// PRBS-16 checker: HUNT -> VERIFY -> LOCKED with flywheel prediction and windowed loss detection.
// Define LFSR_CHECKER_STATS_EN to build the saturating error_count register; otherwise it reads 0.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_COUNT  = 32,
  parameter int LOSS_THRESH = 4,
  parameter int WINDOW      = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bit_valid,
  input  logic        bit_in,
  output logic        locked,
  output logic        error_pulse,
  output logic        sync_lost,
  output logic [15:0] error_count
);

  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int WIN_W  = $clog2(WINDOW + 1);
  localparam int MISS_W = $clog2(LOSS_THRESH + 1);

  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_COUNT);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_THRESH);
  localparam logic [4:0]        FILL_LAST = 5'd15;

  lfsr_state_e       state_q, state_d;
  logic [LFSR_W-1:0] h_q, h_d;
  logic [4:0]        fill_q, fill_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic              locked_q, locked_d;
  logic              error_pulse_q, error_pulse_d;
  logic              sync_lost_q, sync_lost_d;

  logic              predicted;
  logic              mismatch;
  logic [RUN_W-1:0]  run_inc;
  logic [WIN_W-1:0]  win_inc;
  logic [MISS_W-1:0] miss_nx;

  assign predicted = lfsr_predict(h_q);
  assign mismatch  = bit_in ^ predicted;
  assign run_inc   = run_q + RUN_W'(1);
  assign win_inc   = win_q + WIN_W'(1);
  assign miss_nx   = miss_q + MISS_W'(mismatch);

  always_comb begin
    state_d       = state_q;
    h_d           = h_q;
    fill_d        = fill_q;
    run_d         = run_q;
    win_d         = win_q;
    miss_d        = miss_q;
    error_pulse_d = 1'b0;
    sync_lost_d   = 1'b0;

    if (bit_valid) begin
      unique case (state_q)
        ST_HUNT: begin
          h_d = {h_q[LFSR_W-2:0], bit_in};
          if (fill_q == FILL_LAST) begin
            fill_d = '0;
            if (h_d != '0) begin
              state_d = ST_VERIFY;
            end
          end else begin
            fill_d = fill_q + 5'd1;
          end
        end
        ST_VERIFY: begin
          h_d = {h_q[LFSR_W-2:0], bit_in};
          if (!mismatch) begin
            if (run_inc == RUN_LAST) begin
              run_d   = '0;
              state_d = ST_LOCKED;
            end else begin
              run_d = run_inc;
            end
          end else begin
            run_d   = '0;
            fill_d  = '0;
            state_d = ST_HUNT;
          end
        end
        ST_LOCKED: begin
          // Flywheel: shift in the prediction so a corrupted bit never enters the history
          h_d           = {h_q[LFSR_W-2:0], predicted};
          error_pulse_d = mismatch;
          if (miss_nx == MISS_LAST) begin
            state_d     = ST_HUNT;
            sync_lost_d = 1'b1;
            fill_d      = '0;
            run_d       = '0;
            win_d       = '0;
            miss_d      = '0;
          end else if (win_inc == WIN_LAST) begin
            win_d  = '0;
            miss_d = '0;
          end else begin
            win_d  = win_inc;
            miss_d = miss_nx;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_HUNT;
      h_q           <= '0;
      fill_q        <= '0;
      run_q         <= '0;
      win_q         <= '0;
      miss_q        <= '0;
      locked_q      <= 1'b0;
      error_pulse_q <= 1'b0;
      sync_lost_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_q           <= h_d;
      fill_q        <= fill_d;
      run_q         <= run_d;
      win_q         <= win_d;
      miss_q        <= miss_d;
      locked_q      <= locked_d;
      error_pulse_q <= error_pulse_d;
      sync_lost_q   <= sync_lost_d;
    end
  end

  assign locked      = locked_q;
  assign error_pulse = error_pulse_q;
  assign sync_lost   = sync_lost_q;

`ifdef LFSR_CHECKER_STATS_EN
  lfsr_sat_counter #(
    .WIDTH(16)
  ) u_err_cnt (
    .clk  (clk),
    .clr  (reset),
    .en   (error_pulse_d),
    .count(error_count)
  );
`else
  assign error_count = '0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker: directed lock/loss scenarios plus randomized
// traffic compared every cycle against a bit-stream level reference model.
`timescale 1ns/1ps
module tb_lfsr_checker;
  import lfsr_pkg::*;

  localparam int LOCK_COUNT  = 32;
  localparam int LOSS_THRESH = 4;
  localparam int WINDOW      = 64;
`ifdef LFSR_CHECKER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bit_valid = 1'b0;
  logic        bit_in = 1'b0;
  logic        locked;
  logic        error_pulse;
  logic        sync_lost;
  logic [15:0] error_count;

  always #5 clk = ~clk;

  lfsr_checker #(
    .LOCK_COUNT (LOCK_COUNT),
    .LOSS_THRESH(LOSS_THRESH),
    .WINDOW     (WINDOW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .locked     (locked),
    .error_pulse(error_pulse),
    .sync_lost  (sync_lost),
    .error_count(error_count)
  );

  int compared = 0;
  int mismatched = 0;

  // Transmit side: recent generator outputs, index k = (k+1) bits ago
  bit genPast[$];
  int bitsSent;
  int pulsesSeen, lostSeen, lockBit;

  // Reference model of the receiver, kept as a bit-stream history and plain counters
  int mMode;  // 0 hunting, 1 verifying, 2 locked
  bit mRecent[$];
  int mFill, mRun, mWin, mMiss, mErrCnt;
  bit expLocked, expErr, expLost;

  task automatic checkSig(input string name, input logic [15:0] actual, input logic [15:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkInt(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic genReset();
    genPast.delete();
    for (int k = 0; k < LFSR_W; k++) genPast.push_back(LFSR_SEED[k]);
  endtask

  // Stream rule x[n] = x[n-16] ^ x[n-14] ^ x[n-13] ^ x[n-11]
  task automatic genNext(output bit b);
    b = genPast[15] ^ genPast[13] ^ genPast[12] ^ genPast[10];
    genPast.push_front(b);
    void'(genPast.pop_back());
  endtask

  task automatic modelReset();
    mMode = 0;
    mRecent.delete();
    repeat (LFSR_W) mRecent.push_back(1'b0);
    mFill = 0; mRun = 0; mWin = 0; mMiss = 0; mErrCnt = 0;
    expLocked = 1'b0; expErr = 1'b0; expLost = 1'b0;
  endtask

  task automatic modelStep(input bit v, input bit b, input bit r);
    bit p;
    bit anyOne;
    expErr  = 1'b0;
    expLost = 1'b0;
    if (r) begin
      modelReset();
      return;
    end
    if (!v) return;
    p = mRecent[15] ^ mRecent[13] ^ mRecent[12] ^ mRecent[10];
    if (mMode == 0) begin
      mRecent.push_front(b); void'(mRecent.pop_back());
      mFill++;
      if (mFill == 16) begin
        mFill = 0;
        anyOne = 1'b0;
        foreach (mRecent[k]) if (mRecent[k]) anyOne = 1'b1;
        if (anyOne) mMode = 1;
      end
    end else if (mMode == 1) begin
      mRecent.push_front(b); void'(mRecent.pop_back());
      if (b == p) begin
        mRun++;
        if (mRun == LOCK_COUNT) begin mMode = 2; mRun = 0; end
      end else begin
        mRun = 0; mFill = 0; mMode = 0;
      end
    end else begin
      mRecent.push_front(p); void'(mRecent.pop_back());
      mWin++;
      if (b != p) begin
        expErr = 1'b1;
        mMiss++;
        if (mErrCnt < 65535) mErrCnt++;
      end
      if (mMiss == LOSS_THRESH) begin
        mMode = 0; expLost = 1'b1;
        mFill = 0; mRun = 0; mWin = 0; mMiss = 0;
      end else if (mWin == WINDOW) begin
        mWin = 0; mMiss = 0;
      end
    end
    expLocked = (mMode == 2);
  endtask

  task automatic checkOutput();
    checkSig("locked", {15'd0, locked}, {15'd0, expLocked});
    checkSig("error_pulse", {15'd0, error_pulse}, {15'd0, expErr});
    checkSig("sync_lost", {15'd0, sync_lost}, {15'd0, expLost});
    checkSig("error_count", error_count, STATS ? 16'(mErrCnt) : 16'd0);
  endtask

  // Drive one cycle, advance the model on the sampling edge, compare on the falling edge
  task automatic applyStimulus(input bit v, input bit b, input bit r);
    bit_valid = v;
    bit_in    = b;
    reset     = r;
    @(posedge clk);
    modelStep(v, b, r);
    if (r) bitsSent = 0;
    else if (v) bitsSent++;
    @(negedge clk);
    checkOutput();
    if (error_pulse === 1'b1) pulsesSeen++;
    if (sync_lost === 1'b1) lostSeen++;
    if (locked === 1'b1 && lockBit < 0) lockBit = bitsSent;
  endtask

  task automatic sendGen(input bit flip);
    bit g;
    genNext(g);
    applyStimulus(1'b1, g ^ flip, 1'b0);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 1'b1);
    genReset();
    pulsesSeen = 0;
    lostSeen   = 0;
    lockBit    = -1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion earlier");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int drops, lostBit, relockBit, lockCycle, cyc;
    bit g;
    modelReset();
    genReset();
    bitsSent = 0;

    // Clean stream: lock exactly after bit 48, no errors over 1000 bits
    doReset();
    checkSig("reset_locked", {15'd0, locked}, 16'd0);
    checkSig("reset_error_count", error_count, 16'd0);
    repeat (1000) sendGen(1'b0);
    checkInt("clean_lock_bit", lockBit, 48);
    checkSig("clean_error_count", error_count, 16'd0);
    checkInt("clean_pulses", pulsesSeen, 0);

    // Single inverted bit while locked
    doReset();
    drops = 0;
    for (int n = 1; n <= 300; n++) begin
      sendGen(n == 100);
      if (n >= 48 && locked !== 1'b1) drops++;
    end
    checkInt("single_err_pulses", pulsesSeen, 1);
    checkSig("single_err_count", error_count, STATS ? 16'd1 : 16'd0);
    checkInt("single_err_lock_drops", drops, 0);

    // Four misses in one window: loss at bit 90, relock 48 bits later, count retained
    doReset();
    lostBit = -1;
    relockBit = -1;
    for (int n = 1; n <= 200; n++) begin
      sendGen((n inside {60, 70, 80, 90, 150}));
      if (sync_lost === 1'b1 && lostBit < 0) lostBit = n;
      if (lostBit > 0 && n > lostBit && locked === 1'b1 && relockBit < 0) relockBit = n;
      if (n == 90) checkSig("loss_locked_low", {15'd0, locked}, 16'd0);
      if (n == 140) checkSig("loss_count_kept", error_count, STATS ? 16'd4 : 16'd0);
    end
    checkInt("loss_pulses", lostSeen, 1);
    checkInt("loss_bit", lostBit, 90);
    checkInt("relock_bit", relockBit, 138);
    checkSig("loss_count_after_relock", error_count, STATS ? 16'd5 : 16'd0);

    // Window edge: 3 misses ending on the 64th window bit, then 4 in the next window
    doReset();
    lostBit = -1;
    for (int n = 1; n <= 200; n++) begin
      sendGen((n inside {110, 111, 112, 113, 114, 115, 116}));
      if (sync_lost === 1'b1 && lostBit < 0) lostBit = n;
      if (n == 115) checkSig("window_edge_still_locked", {15'd0, locked}, 16'd1);
    end
    checkInt("window_edge_loss_bit", lostBit, 116);

    // All-zero input never locks
    doReset();
    repeat (200) applyStimulus(1'b1, 1'b0, 1'b0);
    checkInt("zeros_lock_bit", lockBit, -1);

    // Sparse valid: one bit every 3rd cycle, then reset coinciding with a 4th miss
    doReset();
    lockCycle = -1;
    cyc = 0;
    while (bitsSent < 60 && cyc < 400) begin
      cyc++;
      if (cyc % 3 == 0) sendGen(((bitsSent + 1) inside {55, 56, 57}));
      else applyStimulus(1'b0, $urandom_range(0, 1) == 1, 1'b0);
      if (locked === 1'b1 && lockCycle < 0) lockCycle = cyc;
    end
    checkInt("sparse_lock_bit", lockBit, 48);
    checkInt("sparse_lock_cycle", lockCycle, 144);
    checkSig("sparse_error_count", error_count, STATS ? 16'd3 : 16'd0);
    genNext(g);
    applyStimulus(1'b1, ~g, 1'b1);
    checkSig("reset_mid_lock_locked", {15'd0, locked}, 16'd0);
    checkSig("reset_mid_lock_sync_lost", {15'd0, sync_lost}, 16'd0);
    checkSig("reset_mid_lock_error_pulse", {15'd0, error_pulse}, 16'd0);
    checkSig("reset_mid_lock_error_count", error_count, 16'd0);
    genReset();

    // Randomized traffic: gaps, sparse bit errors, occasional resets
    doReset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) doReset();
      else if ($urandom_range(0, 9) < 7) sendGen($urandom_range(0, 99) < 2);
      else applyStimulus(1'b0, $urandom_range(0, 1) == 1, 1'b0);
    end

    $display("[TB] stimulus complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
